// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a one-cycle turnaround between owners.
// Optional transfer watchdog enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
  parameter  int MASTERS        = 2,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDW            = (MASTERS > 2) ? $clog2(MASTERS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MASTERS-1:0] bus_req,
  output logic [MASTERS-1:0] bus_grant,
  input  logic               rd_bus,
  input  logic               wr_bus,
  input  logic               fc_bus,
  output logic               bus_busy,
  output logic [IDW-1:0]     grant_id,
  output logic               timeout_err
);

  localparam logic [1:0]     S_IDLE    = 2'd0;
  localparam logic [1:0]     S_GRANTED = 2'd1;
  localparam logic [1:0]     S_RELEASE = 2'd2;
  localparam logic [IDW-1:0] LAST_ID   = IDW'(MASTERS - 1);

  logic [1:0]         state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     ptr_nxt_s;
  logic [MASTERS-1:0] elig_s;
  logic               owner_req_s;
  logic               wd_fire_s;
  logic               pick_vld_s;
  logic [IDW-1:0]     pick_id_s;
  logic [IDW:0]       sum_s;
  logic [IDW-1:0]     idx_s;

  assign owner_req_s = bus_req[gid_q];
  assign ptr_nxt_s   = (gid_q == LAST_ID) ? '0 : gid_q + IDW'(1);

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  WD_LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0]      wd_q, wd_d;
  logic [MASTERS-1:0] mask_q, mask_d;
  logic               tout_q;

  // An offender stays masked until its request has been seen low once.
  assign wd_fire_s = (state_q == S_GRANTED) && owner_req_s && (wd_q == WD_LIMIT);
  assign elig_s    = bus_req & ~mask_q;
  assign mask_d    = (mask_q & bus_req) | (wd_fire_s ? grant_q : '0);

  // Watchdog counts only stalled transfers: strobe active, no completion.
  always_comb begin
    if ((state_q != S_GRANTED) || fc_bus || !(rd_bus || wr_bus) || (wd_q == WD_LIMIT)) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + CW'(1);
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q   <= '0;
      mask_q <= '0;
      tout_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      mask_q <= mask_d;
      tout_q <= wd_fire_s;
    end
  end

  assign timeout_err = tout_q;
`else
  logic unused_s;
  assign unused_s    = (^{rd_bus, wr_bus, fc_bus}) ^ (TIMEOUT_CYCLES > 0);
  assign wd_fire_s   = 1'b0;
  assign elig_s      = bus_req;
  assign timeout_err = 1'b0;
`endif

  // First eligible requester at or after the pointer; lowest offset wins.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_id_s  = '0;
    sum_s      = '0;
    idx_s      = '0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      sum_s      = {1'b0, ptr_q} + (IDW + 1)'(i);
      idx_s      = (sum_s >= (IDW + 1)'(MASTERS)) ? IDW'(sum_s - (IDW + 1)'(MASTERS)) : IDW'(sum_s);
      pick_id_s  = elig_s[idx_s] ? idx_s : pick_id_s;
      pick_vld_s = pick_vld_s | elig_s[idx_s];
    end
  end

  // Arbitration state machine.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld_s) begin
          state_d = S_GRANTED;
          grant_d = {{(MASTERS - 1){1'b0}}, 1'b1} << pick_id_s;
          busy_d  = 1'b1;
          gid_d   = pick_id_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANTED: begin
        if (!owner_req_s || wd_fire_s) begin
          state_d = S_RELEASE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_nxt_s;
        end else begin
          state_d = S_GRANTED;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Arbiter registers; all outputs come straight from here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus_grant = grant_q;
  assign bus_busy  = busy_q;
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (4 masters, default build without the watchdog).
module tb_bus_arbiter;

  localparam int M   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [M-1:0]   req = '0;
  logic           rd  = 1'b0;
  logic           wr  = 1'b0;
  logic           fc  = 1'b0;
  logic [M-1:0]   bus_grant;
  logic           bus_busy;
  logic [IDW-1:0] grant_id;
  logic           timeout_err;

  bus_arbiter #(.MASTERS(M), .TIMEOUT_CYCLES(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_req     (req),
    .bus_grant   (bus_grant),
    .rd_bus      (rd),
    .wr_bus      (wr),
    .fc_bus      (fc),
    .bus_busy    (bus_busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] id;
  } vec_t;

  vec_t tbl [27];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: owner index (-1 none), turnaround flag, pointer, last owner.
  int m_owner = -1;
  bit m_rel   = 1'b0;
  int m_ptr   = 0;
  int m_last  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] g, input logic [1:0] id);
    chk({nm, ".grant"}, 32'(bus_grant), 32'(g));
    chk({nm, ".busy"}, 32'(bus_busy), 32'(|g));
    chk({nm, ".id"}, 32'(grant_id), 32'(id));
    chk({nm, ".tout"}, 32'(timeout_err), 32'd0);
  endtask

  // One clock edge of the arbiter described in plain integer terms.
  task automatic model_tick(input logic r, input logic [3:0] q);
    int c;
    if (!r) begin
      m_owner = -1; m_rel = 1'b0; m_ptr = 0; m_last = 0;
    end else if (m_owner >= 0) begin
      if (!q[m_owner]) begin
        m_ptr   = (m_owner + 1) % M;
        m_owner = -1;
        m_rel   = 1'b1;
      end
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else begin
      for (int k = 0; k < M; k++) begin
        c = (m_ptr + k) % M;
        if (q[c]) begin
          m_owner = c;
          m_last  = c;
          break;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_g;
    one = 4'b0001;

    // rst, req applied before the edge; grant, id expected after it
    tbl[0]  = '{1'b0, 4'b0011, 4'b0000, 2'd0};
    tbl[1]  = '{1'b0, 4'b0011, 4'b0000, 2'd0};
    tbl[2]  = '{1'b0, 4'b0011, 4'b0000, 2'd0};
    tbl[3]  = '{1'b1, 4'b0011, 4'b0001, 2'd0};
    tbl[4]  = '{1'b1, 4'b0011, 4'b0001, 2'd0};
    tbl[5]  = '{1'b1, 4'b0010, 4'b0000, 2'd0};
    tbl[6]  = '{1'b1, 4'b0010, 4'b0000, 2'd0};
    tbl[7]  = '{1'b1, 4'b0010, 4'b0010, 2'd1};
    tbl[8]  = '{1'b1, 4'b0011, 4'b0010, 2'd1};
    tbl[9]  = '{1'b1, 4'b0001, 4'b0000, 2'd1};
    tbl[10] = '{1'b1, 4'b0001, 4'b0000, 2'd1};
    tbl[11] = '{1'b1, 4'b0001, 4'b0001, 2'd0};
    tbl[12] = '{1'b1, 4'b1101, 4'b0001, 2'd0};
    tbl[13] = '{1'b1, 4'b1100, 4'b0000, 2'd0};
    tbl[14] = '{1'b1, 4'b1100, 4'b0000, 2'd0};
    tbl[15] = '{1'b1, 4'b1100, 4'b0100, 2'd2};
    tbl[16] = '{1'b0, 4'b0101, 4'b0000, 2'd0};
    tbl[17] = '{1'b1, 4'b0101, 4'b0001, 2'd0};
    tbl[18] = '{1'b1, 4'b0100, 4'b0000, 2'd0};
    tbl[19] = '{1'b1, 4'b1100, 4'b0000, 2'd0};
    tbl[20] = '{1'b1, 4'b1000, 4'b1000, 2'd3};
    tbl[21] = '{1'b1, 4'b0001, 4'b0000, 2'd3};
    tbl[22] = '{1'b1, 4'b0011, 4'b0000, 2'd3};
    tbl[23] = '{1'b1, 4'b0011, 4'b0001, 2'd0};
    tbl[24] = '{1'b1, 4'b0000, 4'b0000, 2'd0};
    tbl[25] = '{1'b1, 4'b0000, 4'b0000, 2'd0};
    tbl[26] = '{1'b1, 4'b0000, 4'b0000, 2'd0};

    step();
    for (int i = 0; i < 27; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].id);
    end

    // Hold: owner keeps the bus for 20 cycles while another master waits
    req = 4'b0001;
    step();
    chk_out("hold.start", 4'b0001, 2'd0);
    req = 4'b0011; rd = 1'b1; fc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_out($sformatf("hold%0d", i), 4'b0001, 2'd0);
    end
    rd  = 1'b0;
    req = 4'b0010;
    step(); chk_out("hold.drop", 4'b0000, 2'd0);
    step(); chk_out("hold.release", 4'b0000, 2'd0);
    step(); chk_out("hold.next", 4'b0010, 2'd1);

    // Single master pulses its request low for one cycle
    step(); chk_out("single.hold", 4'b0010, 2'd1);
    req = 4'b0000;
    step(); chk_out("single.drop", 4'b0000, 2'd1);
    req = 4'b0010;
    step(); chk_out("single.release", 4'b0000, 2'd1);
    step(); chk_out("single.regrant", 4'b0010, 2'd1);
    req = 4'b0000;
    step(); step(); step();
    chk_out("single.idle", 4'b0000, 2'd1);

    // Round robin: all request, each owner keeps 3 cycles then drops for one
    rst = 1'b0; req = 4'b1111;
    step(); chk_out("rr.reset", 4'b0000, 2'd0);
    rst = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      exp_g = one << (k % M);
      chk_out($sformatf("rr%0d.c1", k), exp_g, 2'(k % M));
      step(); chk_out($sformatf("rr%0d.c2", k), exp_g, 2'(k % M));
      step(); chk_out($sformatf("rr%0d.c3", k), exp_g, 2'(k % M));
      req = 4'b1111 & ~exp_g;
      step(); chk_out($sformatf("rr%0d.drop", k), 4'b0000, 2'(k % M));
      req = 4'b1111;
      step(); chk_out($sformatf("rr%0d.gap", k), 4'b0000, 2'(k % M));
      step();
    end

    // Randomised traffic against the reference model
    rst = 1'b0;
    model_tick(rst, req);
    step();
    chk_out("rand.reset", 4'b0000, 2'd0);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      for (int b = 0; b < M; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      fc = 1'($urandom_range(0, 1));
      model_tick(rst, req);
      step();
      exp_g = (m_owner >= 0) ? (one << m_owner) : 4'b0000;
      chk_out($sformatf("rand%0d", n), exp_g, 2'(m_last));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
